// File: rtl/thermal_overlay_mixer_pkg.sv
// Shared types and constants for the thermal overlay mixer.
// Holds the tile enum, the RGB and hot-spot types, and the pixel bundle carried down the delay line.
package package_thermal;

    typedef enum logic [1:0] {
        TILE_GREY    = 2'd0,
        TILE_INFERNO = 2'd1,
        TILE_TURBO   = 2'd2,
        TILE_MAGMA   = 2'd3
    } t_tile;

    typedef logic [2:0][7:0] t_rgb;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic [7:0] val;
    } t_hot_spot;

    localparam t_rgb c_cursor_rgb = {8'hFF, 8'hFF, 8'hFF};

    // One raster pixel plus its tile decode, aligned with the palette data.
    typedef struct packed {
        logic       hsync;
        logic       vsync;
        logic       de;
        t_rgb       cam;
        logic       tv;
        t_tile      tile;
        logic [4:0] sx;
        logic [4:0] sy;
        logic       border;
    } t_pix;

endpackage

// File: rtl/thermal_overlay_mixer_hot_spot_tracker.sv
// Per-frame hottest-pixel tracker: running max over tile-0 data, latched on each frame edge.
// Ports: i_clk, i_rst, i_vsync, i_valid/i_x/i_y/i_data (returned pixel), o_hot (latched spot).
module hot_spot_tracker
    import package_thermal::*;
#(
    parameter bit p_vsync_pol = 1'b1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_vsync,
    input  logic       i_valid,
    input  logic [4:0] i_x,
    input  logic [4:0] i_y,
    input  logic [7:0] i_data,
    output t_hot_spot  o_hot
);

    typedef enum logic {S_IDLE, S_TRACK} t_state;

    t_state    state_q, state_d;
    logic      vs_act_q;
    logic      frame_edge;
    logic      upd;
    t_hot_spot run_q, run_d;
    t_hot_spot hot_q, hot_d;

    assign frame_edge = (i_vsync == p_vsync_pol) && !vs_act_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            vs_act_q <= 1'b0;
            run_q    <= '0;
            hot_q    <= '0;
        end else begin
            state_q  <= state_d;
            vs_act_q <= (i_vsync == p_vsync_pol);
            run_q    <= run_d;
            hot_q    <= hot_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (frame_edge) state_d = S_TRACK;
            S_TRACK: state_d = S_TRACK;
            default: state_d = S_IDLE;
        endcase
    end

    // A frame edge wins over a coincident update: the latch sees the
    // pre-update values and the new sample is discarded.
    always_comb begin
        upd   = (state_q == S_TRACK) && !frame_edge && i_valid
              && (i_data > run_q.val);
        run_d = run_q;
        hot_d = hot_q;
        if (frame_edge) begin
            hot_d = run_q;
            run_d = '0;
        end else if (upd) begin
            run_d = '{x: i_x, y: i_y, val: i_data};
        end
    end

    assign o_hot = hot_q;

endmodule

// File: rtl/thermal_overlay_mixer.sv
// Composites a 2x2 grid of upscaled thermal tiles over the camera image, with hot-spot cursor.
// Ports: raster timing/position/camera in, framebuffer read out, palette colours in, delayed timing, colours and hot spot out.
module thermal_overlay_mixer
    import package_thermal::*;
#(
    parameter int p_sensor_w   = 32,
    parameter int p_sensor_h   = 24,
    parameter int p_scale_log2 = 3,
    parameter int p_addr_width = 10,
    parameter int p_rd_latency = 2,
    parameter bit p_mirror     = 1'b1,
    parameter bit p_vsync_pol  = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_hsync,
    input  logic                    i_vsync,
    input  logic                    i_de,
    input  logic signed [15:0]      i_x_pos,
    input  logic signed [15:0]      i_y_pos,
    input  t_rgb                    i_cam_colors,
    output logic                    o_fb_rd_valid,
    output logic [p_addr_width-1:0] o_fb_rd_addr,
    input  logic [7:0]              i_fb_rd_data,
    input  t_rgb                    i_grey_colors,
    input  t_rgb                    i_turbo_colors,
    input  t_rgb                    i_inferno_colors,
    input  t_rgb                    i_magma_colors,
    input  logic                    i_cursor_en,
    output logic                    o_hsync,
    output logic                    o_vsync,
    output logic                    o_de,
    output t_rgb                    o_colors,
    output logic [4:0]              o_hot_x,
    output logic [4:0]              o_hot_y,
    output logic [7:0]              o_hot_val
);

    localparam logic signed [15:0] c_w  = 16'(p_sensor_w);
    localparam logic signed [15:0] c_h  = 16'(p_sensor_h);
    localparam logic signed [15:0] c_w2 = 16'(2 * p_sensor_w);
    localparam logic signed [15:0] c_h2 = 16'(2 * p_sensor_h);
    localparam logic [4:0] c_col_max = 5'(p_sensor_w - 1);
    localparam logic [p_addr_width-1:0] c_w_a = p_addr_width'(p_sensor_w);

    logic signed [15:0]      tx, ty;
    logic                    right, bottom, in_tile, border;
    logic [4:0]              sx, sy, col;
    logic [p_scale_log2-1:0] x_sub, y_sub;
    logic                    rd_valid_d, rd_valid_q;
    logic [p_addr_width-1:0] rd_addr_d, rd_addr_q;
    t_pix                    pix_d;
    t_pix                    dl_q [0:p_rd_latency];
    t_pix                    pd;
    t_rgb                    pal, colors_d, colors_q;
    logic                    hsync_q, vsync_q, de_q;
    logic                    cursor_hit, hot_valid;
    t_hot_spot               hot;

    always_comb begin
        tx      = i_x_pos >>> p_scale_log2;
        ty      = i_y_pos >>> p_scale_log2;
        right   = tx >= c_w;
        bottom  = ty >= c_h;
        // Sign bits reject negative positions before the range checks.
        in_tile = !i_x_pos[15] && !i_y_pos[15] && (tx < c_w2) && (ty < c_h2);
        sx      = right  ? 5'(tx - c_w) : 5'(tx);
        sy      = bottom ? 5'(ty - c_h) : 5'(ty);
        col     = p_mirror ? c_col_max - sx : sx;
        x_sub   = i_x_pos[p_scale_log2-1:0];
        y_sub   = i_y_pos[p_scale_log2-1:0];
        border  = (&x_sub) || (~|x_sub) || (&y_sub) || (~|y_sub);
        rd_valid_d = i_de && in_tile;
        rd_addr_d  = rd_valid_d
                   ? p_addr_width'(sy) * c_w_a + p_addr_width'(col)
                   : '0;
        pix_d = '{hsync: i_hsync, vsync: i_vsync, de: i_de,
                  cam: i_cam_colors, tv: in_tile,
                  tile: t_tile'({bottom, right}),
                  sx: sx, sy: sy, border: border};
    end

    // Request register plus a delay line one stage longer than the read
    // latency, so dl_q[p_rd_latency] lines up with the returned data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            for (int i = 0; i <= p_rd_latency; i++) dl_q[i] <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            dl_q[0]    <= pix_d;
            for (int i = 1; i <= p_rd_latency; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    assign pd        = dl_q[p_rd_latency];
    assign hot_valid = pd.de && pd.tv && (pd.tile == TILE_GREY);

    always_comb begin
        pal = i_grey_colors;
        unique case (pd.tile)
            TILE_GREY:    pal = i_grey_colors;
            TILE_INFERNO: pal = i_inferno_colors;
            TILE_TURBO:   pal = i_turbo_colors;
            TILE_MAGMA:   pal = i_magma_colors;
        endcase
        cursor_hit = i_cursor_en && pd.tv && pd.border
                   && (pd.sx == hot.x) && (pd.sy == hot.y);
        if (!pd.de)          colors_d = '0;
        else if (cursor_hit) colors_d = c_cursor_rgb;
        else if (pd.tv)      colors_d = pal;
        else                 colors_d = pd.cam;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            de_q     <= 1'b0;
            colors_q <= '0;
        end else begin
            hsync_q  <= pd.hsync;
            vsync_q  <= pd.vsync;
            de_q     <= pd.de;
            colors_q <= colors_d;
        end
    end

    hot_spot_tracker #(
        .p_vsync_pol (p_vsync_pol)
    ) u_hot (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_vsync (i_vsync),
        .i_valid (hot_valid),
        .i_x     (pd.sx),
        .i_y     (pd.sy),
        .i_data  (i_fb_rd_data),
        .o_hot   (hot)
    );

    assign o_fb_rd_valid = rd_valid_q;
    assign o_fb_rd_addr  = rd_addr_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_de          = de_q;
    assign o_colors      = colors_q;
    assign o_hot_x       = hot.x;
    assign o_hot_y       = hot.y;
    assign o_hot_val     = hot.val;

endmodule

// File: tb/tb_thermal_overlay_mixer.sv
// Self-checking bench for thermal_overlay_mixer with a framebuffer/palette model.
// Expected pixels are queued at drive time and popped when the output is due.
module tb_thermal_overlay_mixer;
    import package_thermal::*;

    localparam int L   = 2;
    localparam int LAT = L + 2;

    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic               de;
        logic               hs;
        logic               vs;
        t_rgb               cam;
    } stim_t;

    typedef struct {
        int   due;
        logic hs;
        logic vs;
        logic de;
        t_rgb col;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               hs, vs, de, cen;
    logic signed [15:0] x, y;
    t_rgb               cam;
    logic               rd_valid;
    logic [9:0]         rd_addr;
    logic [7:0]         fb_data;
    t_rgb               grey, turbo, inferno, magma;
    logic               o_hs, o_vs, o_de;
    t_rgb               o_col;
    logic [4:0]         hot_x, hot_y;
    logic [7:0]         hot_val;

    logic [7:0] fb_mem [0:767];
    logic [9:0] ap [0:L];

    exp_t       sb [$];
    int         checks = 0;
    int         failures = 0;
    int         ncyc = 0;
    logic [4:0] exp_hx = 5'd0;
    logic [4:0] exp_hy = 5'd0;

    always #5 clk = ~clk;

    thermal_overlay_mixer #(.p_rd_latency(L)) dut (
        .i_clk            (clk),
        .i_rst            (rst),
        .i_hsync          (hs),
        .i_vsync          (vs),
        .i_de             (de),
        .i_x_pos          (x),
        .i_y_pos          (y),
        .i_cam_colors     (cam),
        .o_fb_rd_valid    (rd_valid),
        .o_fb_rd_addr     (rd_addr),
        .i_fb_rd_data     (fb_data),
        .i_grey_colors    (grey),
        .i_turbo_colors   (turbo),
        .i_inferno_colors (inferno),
        .i_magma_colors   (magma),
        .i_cursor_en      (cen),
        .o_hsync          (o_hs),
        .o_vsync          (o_vs),
        .o_de             (o_de),
        .o_colors         (o_col),
        .o_hot_x          (hot_x),
        .o_hot_y          (hot_y),
        .o_hot_val        (hot_val)
    );

    // Framebuffer answers each request L cycles later.
    always @(negedge clk) begin
        ap[0] <= rd_addr;
        for (int i = 1; i <= L; i++) ap[i] <= ap[i-1];
    end
    assign fb_data = fb_mem[ap[L]];
    assign grey    = {fb_data, fb_data, fb_data};
    assign inferno = {fb_data, 8'h10, ~fb_data};
    assign turbo   = {~fb_data, fb_data, 8'h20};
    assign magma   = {8'h30, ~fb_data, fb_data};

    function automatic void model(input stim_t s, input logic c_en,
                                  output exp_t e, output logic rv,
                                  output logic [9:0] ra);
        int px, py, sxm, sym, a, t;
        logic inb, bord;
        logic [7:0] d;
        t_rgb pl;
        px   = int'(s.x);
        py   = int'(s.y);
        inb  = px >= 0 && py >= 0 && px < 512 && py < 384;
        sxm  = (px / 8) % 32;
        sym  = (py / 8) % 24;
        a    = sym * 32 + 31 - sxm;
        d    = inb ? fb_mem[a] : 8'h00;
        t    = (py >= 192 ? 2 : 0) + (px >= 256 ? 1 : 0);
        case (t)
            0:       pl = {d, d, d};
            1:       pl = {d, 8'h10, ~d};
            2:       pl = {~d, d, 8'h20};
            default: pl = {8'h30, ~d, d};
        endcase
        bord = (px % 8 == 0) || (px % 8 == 7) || (py % 8 == 0) || (py % 8 == 7);
        e.due = 0;
        e.hs  = s.hs;
        e.vs  = s.vs;
        e.de  = s.de;
        if (!s.de)
            e.col = '0;
        else if (inb && c_en && bord && sxm == int'(exp_hx) && sym == int'(exp_hy))
            e.col = {8'hFF, 8'hFF, 8'hFF};
        else if (inb)
            e.col = pl;
        else
            e.col = s.cam;
        rv = s.de && inb;
        ra = rv ? 10'(a) : 10'd0;
    endfunction

    task automatic set_in(input stim_t s);
        x = s.x; y = s.y; de = s.de; hs = s.hs; vs = s.vs; cam = s.cam;
    endtask

    task automatic set_idle();
        x = '0; y = '0; de = 1'b0; hs = 1'b0; vs = 1'b0; cam = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; cen = 1'b0;
        x = 16'sd8; y = 16'sd8; de = 1'b1; hs = 1'b1; vs = 1'b0;
        cam = 24'h123456;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_hs, o_vs, o_de, o_col} !== 27'd0) begin
            failures++;
            $display("FAIL reset_pix got=%b%b%b/%h exp=000/000000", o_hs, o_vs, o_de, o_col);
        end
        checks++;
        if ({rd_valid, rd_addr} !== 11'd0) begin
            failures++;
            $display("FAIL reset_rd got=%b/%0d exp=0/0", rd_valid, rd_addr);
        end
        checks++;
        if ({hot_x, hot_y, hot_val} !== 18'd0) begin
            failures++;
            $display("FAIL reset_hot got=%0d,%0d,%h exp=0,0,00", hot_x, hot_y, hot_val);
        end
        rst = 1'b0;
        set_idle();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_tiles();
        stim_t s [$];
        exp_t e;
        logic rv, pv;
        logic [9:0] ra, pa;
        int n;
        s.push_back('{16'sd0,   16'sd0,   1'b1, 1'b0, 1'b0, 24'hA1B2C3});
        s.push_back('{16'sd263, 16'sd200, 1'b1, 1'b0, 1'b0, 24'h010203});
        s.push_back('{16'sd600, 16'sd10,  1'b1, 1'b1, 1'b0, 24'h445566});
        s.push_back('{-16'sd1,  16'sd5,   1'b1, 1'b0, 1'b0, 24'h778899});
        s.push_back('{16'sd300, 16'sd20,  1'b1, 1'b0, 1'b0, 24'h0A0B0C});
        s.push_back('{16'sd20,  16'sd250, 1'b1, 1'b0, 1'b0, 24'h0D0E0F});
        s.push_back('{16'sd8,   16'sd0,   1'b0, 1'b1, 1'b0, 24'hABCDEF});
        s.push_back('{16'sd511, 16'sd383, 1'b1, 1'b0, 1'b0, 24'h111111});
        s.push_back('{16'sd512, 16'sd0,   1'b1, 1'b0, 1'b0, 24'h222222});
        n  = s.size();
        pv = 1'b0;
        pa = '0;
        cen = 1'b0;
        for (int i = 0; i < n + LAT; i++) begin
            @(negedge clk);
            ncyc++;
            if (sb.size() > 0 && sb[0].due == ncyc) begin
                e = sb.pop_front();
                checks++;
                if ({o_hs, o_vs, o_de, o_col} !== {e.hs, e.vs, e.de, e.col}) begin
                    failures++;
                    $display("FAIL tiles_pix cyc=%0d got=%b%b%b/%h exp=%b%b%b/%h",
                             ncyc, o_hs, o_vs, o_de, o_col, e.hs, e.vs, e.de, e.col);
                end
            end
            if (i >= 1 && i <= n) begin
                checks++;
                if ({rd_valid, rd_addr} !== {pv, pa}) begin
                    failures++;
                    $display("FAIL tiles_rd idx=%0d got=%b/%0d exp=%b/%0d",
                             i - 1, rd_valid, rd_addr, pv, pa);
                end
            end
            if (i < n) begin
                set_in(s[i]);
                model(s[i], 1'b0, e, rv, ra);
                e.due = ncyc + LAT;
                sb.push_back(e);
                pv = rv;
                pa = ra;
            end else begin
                set_idle();
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL tiles_drain left=%0d exp=0", sb.size());
            sb.delete();
        end
        checks++;
        if ({hot_x, hot_y, hot_val} !== 18'd0) begin
            failures++;
            $display("FAIL tiles_hot_hold got=%0d,%0d,%h exp=0,0,00", hot_x, hot_y, hot_val);
        end
    endtask

    task automatic test_hot_spot();
        stim_t s [$];
        s.push_back('{16'sd0,   16'sd0,  1'b0, 1'b0, 1'b1, 24'h0});
        s.push_back('{16'sd0,   16'sd0,  1'b0, 1'b0, 1'b0, 24'h0});
        s.push_back('{16'sd0,   16'sd0,  1'b1, 1'b0, 1'b0, 24'h0});
        s.push_back('{16'sd40,  16'sd56, 1'b1, 1'b0, 1'b0, 24'h0});
        s.push_back('{16'sd72,  16'sd56, 1'b1, 1'b0, 1'b0, 24'h0});
        s.push_back('{16'sd280, 16'sd16, 1'b1, 1'b0, 1'b0, 24'h0});
        s.push_back('{16'sd8,   16'sd8,  1'b1, 1'b0, 1'b0, 24'h0});
        foreach (s[i]) begin
            @(negedge clk);
            set_in(s[i]);
        end
        repeat (LAT + 2) begin
            @(negedge clk);
            set_idle();
        end
        checks++;
        if ({hot_x, hot_y, hot_val} !== 18'd0) begin
            failures++;
            $display("FAIL hot_empty_frame got=%0d,%0d,%h exp=0,0,00", hot_x, hot_y, hot_val);
        end
        @(negedge clk); vs = 1'b1;
        @(negedge clk); vs = 1'b0;
        @(negedge clk);
        checks++;
        if ({hot_x, hot_y, hot_val} !== {5'd5, 5'd7, 8'h80}) begin
            failures++;
            $display("FAIL hot_tie_first got=%0d,%0d,%h exp=5,7,80", hot_x, hot_y, hot_val);
        end
        exp_hx = 5'd5;
        exp_hy = 5'd7;
    endtask

    task automatic test_cursor();
        stim_t s [$];
        exp_t e;
        logic rv;
        logic [9:0] ra;
        int n;
        s.push_back('{16'sd40,  16'sd56, 1'b1, 1'b0, 1'b0, 24'h010101});
        s.push_back('{16'sd47,  16'sd63, 1'b1, 1'b0, 1'b0, 24'h020202});
        s.push_back('{16'sd44,  16'sd60, 1'b1, 1'b0, 1'b0, 24'h030303});
        s.push_back('{16'sd296, 16'sd56, 1'b1, 1'b0, 1'b0, 24'h040404});
        s.push_back('{16'sd43,  16'sd56, 1'b1, 1'b0, 1'b0, 24'h050505});
        s.push_back('{16'sd48,  16'sd56, 1'b1, 1'b0, 1'b0, 24'h060606});
        s.push_back('{16'sd600, 16'sd10, 1'b1, 1'b0, 1'b0, 24'h070707});
        n = s.size();
        cen = 1'b1;
        for (int i = 0; i < n + LAT; i++) begin
            @(negedge clk);
            ncyc++;
            if (sb.size() > 0 && sb[0].due == ncyc) begin
                e = sb.pop_front();
                checks++;
                if ({o_hs, o_vs, o_de, o_col} !== {e.hs, e.vs, e.de, e.col}) begin
                    failures++;
                    $display("FAIL cursor_pix cyc=%0d got=%b%b%b/%h exp=%b%b%b/%h",
                             ncyc, o_hs, o_vs, o_de, o_col, e.hs, e.vs, e.de, e.col);
                end
            end
            if (i < n) begin
                set_in(s[i]);
                model(s[i], 1'b1, e, rv, ra);
                e.due = ncyc + LAT;
                sb.push_back(e);
            end else begin
                set_idle();
            end
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL cursor_drain left=%0d exp=0", sb.size());
            sb.delete();
        end
        cen = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        @(negedge clk);
        x = 16'sd40; y = 16'sd56; de = 1'b1; hs = 1'b1; cam = 24'h999999;
        @(negedge clk);
        x = 16'sd48;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_hs, o_vs, o_de, o_col} !== 27'd0) begin
            failures++;
            $display("FAIL midrst_pix got=%b%b%b/%h exp=000/000000", o_hs, o_vs, o_de, o_col);
        end
        checks++;
        if ({rd_valid, rd_addr} !== 11'd0) begin
            failures++;
            $display("FAIL midrst_rd got=%b/%0d exp=0/0", rd_valid, rd_addr);
        end
        checks++;
        if ({hot_x, hot_y, hot_val} !== 18'd0) begin
            failures++;
            $display("FAIL midrst_hot got=%0d,%0d,%h exp=0,0,00", hot_x, hot_y, hot_val);
        end
        rst = 1'b0;
        set_idle();
        @(negedge clk); vs = 1'b1;
        @(negedge clk); vs = 1'b0;
        @(negedge clk);
        checks++;
        if ({hot_x, hot_y, hot_val} !== 18'd0) begin
            failures++;
            $display("FAIL hot_after_reset got=%0d,%0d,%h exp=0,0,00", hot_x, hot_y, hot_val);
        end
        @(negedge clk);
        x = 16'sd8; y = 16'sd8; de = 1'b1;
        repeat (3) begin
            @(negedge clk);
            set_idle();
        end
        // Hot pixel whose data returns in the same cycle as the frame edge.
        @(negedge clk);
        x = 16'sd40; y = 16'sd56; de = 1'b1;
        @(negedge clk); set_idle();
        @(negedge clk); set_idle();
        @(negedge clk); vs = 1'b1;
        @(negedge clk); vs = 1'b0;
        @(negedge clk);
        checks++;
        if ({hot_x, hot_y, hot_val} !== {5'd1, 5'd1, 8'd62}) begin
            failures++;
            $display("FAIL hot_edge_collision got=%0d,%0d,%h exp=1,1,3e", hot_x, hot_y, hot_val);
        end
        repeat (3) @(negedge clk);
        vs = 1'b1;
        @(negedge clk); vs = 1'b0;
        @(negedge clk);
        checks++;
        if ({hot_x, hot_y, hot_val} !== 18'd0) begin
            failures++;
            $display("FAIL hot_dropped_update got=%0d,%0d,%h exp=0,0,00", hot_x, hot_y, hot_val);
        end
    endtask

    initial begin
        for (int i = 0; i < 768; i++) fb_mem[i] = 8'(i % 64);
        fb_mem[250] = 8'h80;
        fb_mem[246] = 8'h80;
        fb_mem[92]  = 8'hF0;
        test_reset();
        test_tiles();
        test_hot_spot();
        test_cursor();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
